// File: rtl/xif_pkg.sv
// Shared CV-X-IF types: the default interface result records and the
// per-entry lifecycle of an offloaded instruction in the commit tracker.
package xif_pkg;

  localparam int unsigned X_ID_WIDTH_DEF  = 4;
  localparam int unsigned X_RFW_WIDTH_DEF = 32;
  localparam int unsigned XLEN_DEF        = 32;

  // Lifecycle of one tracker slot
  typedef enum logic [1:0] {
    ENT_FREE      = 2'd0,
    ENT_ISSUED    = 2'd1,
    ENT_COMMITTED = 2'd2,
    ENT_KILLED    = 2'd3
  } ent_state_e;

  // Result as produced by an execution unit
  typedef struct packed {
    logic [X_ID_WIDTH_DEF-1:0]               id;
    logic [X_RFW_WIDTH_DEF-1:0]              data;
    logic [4:0]                              rd;
    logic [X_RFW_WIDTH_DEF/XLEN_DEF-1:0]     we;
    logic                                    exc;
    logic [5:0]                              exccode;
  } x_exec_result_t;

  // Result as presented to the core
  typedef struct packed {
    logic [X_ID_WIDTH_DEF-1:0]               id;
    logic [X_RFW_WIDTH_DEF-1:0]              data;
    logic [4:0]                              rd;
    logic [X_RFW_WIDTH_DEF/XLEN_DEF-1:0]     we;
    logic                                    exc;
    logic [5:0]                              exccode;
  } x_result_t;

endpackage

// File: rtl/xif_id_cam.sv
// Masked ID match over all tracker slots. Returns the lowest matching slot
// as a one-hot vector so callers can update entries without an encoder.
module xif_id_cam #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4
) (
  input  logic [DEPTH-1:0][X_ID_WIDTH-1:0] ids_i,
  input  logic [DEPTH-1:0]                 mask_i,
  input  logic [X_ID_WIDTH-1:0]            key_i,
  output logic [DEPTH-1:0]                 onehot_o,
  output logic                             hit_o
);

  logic found;

  // First masked slot whose ID equals the key wins
  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mask_i[i] && (ids_i[i] == key_i) && !found) begin
        onehot_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/xif_commit_tracker.sv
// In-order commit tracker for offloaded instructions: allocates a slot per
// issue, applies commit/kill and out-of-order execution results, and hands
// one result per committed instruction back to the core in issue order.
module xif_commit_tracker
  import xif_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_RFW_WIDTH = 32,
  parameter int unsigned XLEN        = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [X_ID_WIDTH-1:0]           issue_id_i,
  input  logic                            commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]           commit_id_i,
  input  logic                            commit_kill_i,
  input  logic                            ex_valid_i,
  output logic                            ex_ready_o,
  input  logic [X_ID_WIDTH-1:0]           ex_id_i,
  input  logic [X_RFW_WIDTH-1:0]          ex_data_i,
  input  logic [4:0]                      ex_rd_i,
  input  logic [X_RFW_WIDTH/XLEN-1:0]     ex_we_i,
  input  logic                            ex_exc_i,
  input  logic [5:0]                      ex_exccode_i,
  output logic                            result_valid_o,
  input  logic                            result_ready_i,
  output logic [X_ID_WIDTH-1:0]           result_id_o,
  output logic [X_RFW_WIDTH-1:0]          result_data_o,
  output logic [4:0]                      result_rd_o,
  output logic [X_RFW_WIDTH/XLEN-1:0]     result_we_o,
  output logic                            result_exc_o,
  output logic [5:0]                      result_exccode_o,
  output logic [$clog2(DEPTH+1)-1:0]      outstanding_o,
  output logic                            err_o
);

  localparam int unsigned WE_W  = X_RFW_WIDTH / XLEN;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Stored result payload; the ID lives in id_q from issue time
  typedef struct packed {
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic [WE_W-1:0]        we;
    logic                   exc;
    logic [5:0]             exccode;
  } res_t;

  ent_state_e [DEPTH-1:0]              state_q, state_d;
  logic [DEPTH-1:0]                    has_res_q, has_res_d;
  logic [DEPTH-1:0][X_ID_WIDTH-1:0]    id_q;
  res_t [DEPTH-1:0]                    res_q;
  logic [PTR_W-1:0]                    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                err_q, err_d;

  logic                                issue_fire, dup_id, retire;
  logic [DEPTH-1:0]                    live, cmt_mask, cmt_oh, ex_oh;
  logic [DEPTH-1:0][X_ID_WIDTH-1:0]    cmt_ids;
  logic                                cmt_hit, ex_hit, cmt_ok, ex_wr;

  assign issue_ready_o = (cnt_q < CNT_W'(DEPTH));
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign ex_ready_o    = 1'b1;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Live-slot mask, commit lookup view (includes the slot allocated this cycle)
  // and duplicate-ID detection for the incoming issue
  always_comb begin
    live     = '0;
    dup_id   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = (state_q[i] != ENT_FREE);
      if (live[i] && (id_q[i] == issue_id_i)) dup_id = 1'b1;
    end
    cmt_ids  = id_q;
    cmt_mask = live;
    if (issue_fire) begin
      cmt_ids[tail_q]  = issue_id_i;
      cmt_mask[tail_q] = 1'b1;
    end
  end

  xif_id_cam #(.DEPTH(DEPTH), .X_ID_WIDTH(X_ID_WIDTH)) u_cmt_cam (
    .ids_i    (cmt_ids),
    .mask_i   (cmt_mask),
    .key_i    (commit_id_i),
    .onehot_o (cmt_oh),
    .hit_o    (cmt_hit)
  );

  xif_id_cam #(.DEPTH(DEPTH), .X_ID_WIDTH(X_ID_WIDTH)) u_ex_cam (
    .ids_i    (id_q),
    .mask_i   (live),
    .key_i    (ex_id_i),
    .onehot_o (ex_oh),
    .hit_o    (ex_hit)
  );

  // Commit is legal only against a slot still waiting for its verdict
  always_comb begin
    cmt_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cmt_oh[i] && ((state_q[i] == ENT_ISSUED) ||
                        (issue_fire && (PTR_W'(i) == tail_q)))) begin
        cmt_ok = 1'b1;
      end
    end
  end

  assign ex_wr  = ex_valid_i & ex_hit & ~(|(ex_oh & has_res_q));
  assign retire = has_res_q[head_q] &
                  (((state_q[head_q] == ENT_COMMITTED) & result_ready_i) |
                   (state_q[head_q] == ENT_KILLED));

  // Next-state for slot lifecycle, pointers, occupancy and sticky error
  always_comb begin
    state_d   = state_q;
    has_res_d = has_res_q;
    head_d    = head_q;
    tail_d    = tail_q;
    err_d     = err_q;
    cnt_d     = cnt_q + CNT_W'(issue_fire) - CNT_W'(retire);
    if (issue_valid_i && !issue_ready_o) err_d = 1'b1;
    if (issue_fire) begin
      state_d[tail_q]   = ENT_ISSUED;
      has_res_d[tail_q] = 1'b0;
      tail_d            = tail_q + 1'b1;
      if (dup_id) err_d = 1'b1;
    end
    if (commit_valid_i) begin
      if (!cmt_ok) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cmt_oh[i]) state_d[i] = commit_kill_i ? ENT_KILLED : ENT_COMMITTED;
        end
      end
    end
    if (ex_valid_i && !ex_wr) err_d = 1'b1;
    if (ex_wr) has_res_d = has_res_d | ex_oh;
    if (retire) begin
      state_d[head_q]   = ENT_FREE;
      has_res_d[head_q] = 1'b0;
      head_d            = head_q + 1'b1;
    end
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ENT_FREE;
      has_res_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      has_res_q <= has_res_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Slot payload storage; qualified by slot state, so no reset needed
  always_ff @(posedge clk_i) begin
    if (issue_fire) id_q[tail_q] <= issue_id_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (ex_wr && ex_oh[i]) res_q[i] <= '{ex_data_i, ex_rd_i, ex_we_i, ex_exc_i, ex_exccode_i};
    end
  end

  assign result_valid_o = has_res_q[head_q] & (state_q[head_q] == ENT_COMMITTED);

  // Head result fields, held at zero whenever no result is offered
  always_comb begin
    result_id_o      = '0;
    result_data_o    = '0;
    result_rd_o      = '0;
    result_we_o      = '0;
    result_exc_o     = 1'b0;
    result_exccode_o = '0;
    if (result_valid_o) begin
      result_id_o      = id_q[head_q];
      result_data_o    = res_q[head_q].data;
      result_rd_o      = res_q[head_q].rd;
      result_we_o      = res_q[head_q].we;
      result_exc_o     = res_q[head_q].exc;
      result_exccode_o = res_q[head_q].exccode;
    end
  end

endmodule

// File: tb/tb_xif_commit_tracker.sv
// Randomised and directed bench for xif_commit_tracker against an in-order
// queue model of the outstanding instructions.
module tb_xif_commit_tracker;

  localparam int DEPTH   = 4;
  localparam int ST_ISS  = 0;
  localparam int ST_CMT  = 1;
  localparam int ST_KILL = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0, issue_ready_o;
  logic [3:0]  issue_id_i = '0;
  logic        commit_valid_i = 1'b0, commit_kill_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        ex_valid_i = 1'b0, ex_ready_o;
  logic [3:0]  ex_id_i = '0;
  logic [31:0] ex_data_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic [0:0]  ex_we_i = '0;
  logic        ex_exc_i = 1'b0;
  logic [5:0]  ex_exccode_i = '0;
  logic        result_valid_o, result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic [0:0]  result_we_o;
  logic        result_exc_o;
  logic [5:0]  result_exccode_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  xif_commit_tracker #(.X_ID_WIDTH(4), .DEPTH(DEPTH), .X_RFW_WIDTH(32), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_id_i(ex_id_i), .ex_data_i(ex_data_i),
    .ex_rd_i(ex_rd_i), .ex_we_i(ex_we_i), .ex_exc_i(ex_exc_i), .ex_exccode_i(ex_exccode_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_exc_o(result_exc_o), .result_exccode_o(result_exccode_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  id;
    int          st;
    bit          has_res;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  code;
  } ment_t;

  typedef struct {
    logic        iv;  logic [3:0] iid;
    logic        cv;  logic [3:0] cid; logic ck;
    logic        ev;  logic [3:0] eid; logic [31:0] edata; logic [4:0] erd;
    logic        ewe; logic exc; logic [5:0] ecode;
    logic        rr;
  } stim_t;

  ment_t      mq[$];
  bit         m_err;
  logic [3:0] dut_ret[$];

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rr = 1'b1;
    return s;
  endfunction

  function automatic int find_id(input logic [3:0] id, input int lim);
    for (int k = 0; k < lim; k++) if (mq[k].id == id) return k;
    return -1;
  endfunction

  task automatic check_outputs();
    bit rv;
    rv = (mq.size() > 0) && (mq[0].st == ST_CMT) && mq[0].has_res;
    check_eq("result_valid", result_valid_o, rv);
    if (rv) begin
      check_eq("result_id",      result_id_o,      mq[0].id);
      check_eq("result_data",    result_data_o,    mq[0].data);
      check_eq("result_rd",      result_rd_o,      mq[0].rd);
      check_eq("result_we",      result_we_o,      mq[0].we);
      check_eq("result_exc",     result_exc_o,     mq[0].exc);
      check_eq("result_exccode", result_exccode_o, mq[0].code);
    end
    check_eq("issue_ready", issue_ready_o, mq.size() < DEPTH);
    check_eq("outstanding", outstanding_o, mq.size());
    check_eq("err", err_o, m_err);
    check_eq("ex_ready", ex_ready_o, 1'b1);
  endtask

  // Reference behaviour: in-order list of outstanding instructions
  task automatic model_step(input stim_t s);
    int    pre, k;
    bit    ret;
    ment_t e;
    pre = mq.size();
    ret = (pre > 0) && mq[0].has_res &&
          (((mq[0].st == ST_CMT) && s.rr) || (mq[0].st == ST_KILL));
    if (s.iv) begin
      if (pre < DEPTH) begin
        if (find_id(s.iid, pre) >= 0) m_err = 1'b1;
        e = '{id: s.iid, st: ST_ISS, has_res: 1'b0, data: '0, rd: '0, we: '0, exc: '0, code: '0};
        mq.push_back(e);
      end else begin
        m_err = 1'b1;
      end
    end
    if (s.cv) begin
      k = find_id(s.cid, mq.size());
      if (k < 0 || mq[k].st != ST_ISS) m_err = 1'b1;
      else mq[k].st = s.ck ? ST_KILL : ST_CMT;
    end
    if (s.ev) begin
      k = find_id(s.eid, pre);
      if (k < 0 || mq[k].has_res) m_err = 1'b1;
      else begin
        mq[k].has_res = 1'b1;
        mq[k].data = s.edata; mq[k].rd = s.erd; mq[k].we = s.ewe;
        mq[k].exc = s.exc; mq[k].code = s.ecode;
      end
    end
    if (ret) void'(mq.pop_front());
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk_i);
    check_outputs();
    issue_valid_i = s.iv;  issue_id_i = s.iid;
    commit_valid_i = s.cv; commit_id_i = s.cid; commit_kill_i = s.ck;
    ex_valid_i = s.ev; ex_id_i = s.eid; ex_data_i = s.edata; ex_rd_i = s.erd;
    ex_we_i = s.ewe; ex_exc_i = s.exc; ex_exccode_i = s.ecode;
    result_ready_i = s.rr;
    if (result_valid_o && s.rr) dut_ret.push_back(result_id_o);
    model_step(s);
  endtask

  task automatic drive_idle();
    stim_t s;
    s = idle();
    issue_valid_i = 1'b0; commit_valid_i = 1'b0; ex_valid_i = 1'b0;
    commit_kill_i = 1'b0; result_ready_i = s.rr;
  endtask

  task automatic do_reset();
    drive_idle();
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("rst_result_valid", result_valid_o, 1'b0);
    check_eq("rst_result_id",    result_id_o,    4'd0);
    check_eq("rst_result_data",  result_data_o,  32'd0);
    check_eq("rst_outstanding",  outstanding_o,  3'd0);
    check_eq("rst_err",          err_o,          1'b0);
    check_eq("rst_issue_ready",  issue_ready_o,  1'b1);
    check_eq("rst_ex_ready",     ex_ready_o,     1'b1);
    mq.delete();
    m_err = 1'b0;
    dut_ret.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic do_issue(input logic [3:0] id);
    stim_t s; s = idle(); s.iv = 1'b1; s.iid = id; apply(s);
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    stim_t s; s = idle(); s.cv = 1'b1; s.cid = id; s.ck = kill; apply(s);
  endtask

  task automatic do_ex(input logic [3:0] id, input logic [31:0] d);
    stim_t s; s = idle(); s.ev = 1'b1; s.eid = id; s.edata = d;
    s.erd = 5'(d); s.ewe = 1'b1; s.exc = d[0]; s.ecode = 6'(d >> 2); apply(s);
  endtask

  task automatic do_idle(input int n, input logic rr);
    stim_t s; s = idle(); s.rr = rr;
    for (int k = 0; k < n; k++) apply(s);
  endtask

  task automatic rand_cycle();
    stim_t      s;
    logic [3:0] cands[$];
    int         pre;
    s = idle();
    s.rr = ($urandom_range(0, 3) != 0);
    pre = mq.size();
    if (pre < DEPTH && $urandom_range(0, 1) == 1) begin
      s.iv = 1'b1;
      s.iid = 4'($urandom_range(0, 15));
      while (find_id(s.iid, pre) >= 0) s.iid = 4'($urandom_range(0, 15));
    end
    foreach (mq[k]) if (mq[k].st == ST_ISS) cands.push_back(mq[k].id);
    if (s.iv) cands.push_back(s.iid);
    if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
      s.cv = 1'b1;
      s.cid = cands[$urandom_range(0, cands.size() - 1)];
      s.ck = ($urandom_range(0, 3) == 0);
    end
    cands.delete();
    foreach (mq[k]) if (!mq[k].has_res) cands.push_back(mq[k].id);
    if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
      s.ev = 1'b1;
      s.eid = cands[$urandom_range(0, cands.size() - 1)];
      s.edata = $urandom; s.erd = 5'($urandom); s.ewe = 1'($urandom);
      s.exc = 1'($urandom); s.ecode = 6'($urandom);
    end
    apply(s);
  endtask

  initial begin
    logic [3:0] exp_order[3];
    m_err = 1'b0;

    // In-order return of out-of-order results
    do_reset();
    do_issue(4'd1); do_issue(4'd2); do_issue(4'd3);
    do_commit(4'd1, 1'b0); do_commit(4'd2, 1'b0); do_commit(4'd3, 1'b0);
    do_ex(4'd3, 32'h33); do_ex(4'd1, 32'h11); do_ex(4'd2, 32'h22);
    do_idle(5, 1'b1);
    exp_order = '{4'd1, 4'd2, 4'd3};
    check_eq("order_count", dut_ret.size(), 3);
    for (int k = 0; k < 3 && k < dut_ret.size(); k++) check_eq("order_id", dut_ret[k], exp_order[k]);
    check_eq("drained", outstanding_o, 3'd0);

    // Fill to DEPTH, stay error-free while issue is held off, then free a slot
    do_reset();
    for (int k = 0; k < 4; k++) do_issue(4'(k + 1));
    do_idle(2, 1'b1);
    check_eq("full_ready", issue_ready_o, 1'b0);
    do_commit(4'd1, 1'b0);
    do_ex(4'd1, 32'hA5);
    do_idle(2, 1'b1);
    do_issue(4'd5);
    do_idle(1, 1'b1);

    // Killed head drains silently, next result follows
    do_reset();
    do_issue(4'd7); do_issue(4'd8);
    do_commit(4'd7, 1'b1); do_commit(4'd8, 1'b0);
    do_ex(4'd7, 32'h77); do_ex(4'd8, 32'h88);
    do_idle(3, 1'b1);
    check_eq("kill_retired", dut_ret.size(), 1);
    if (dut_ret.size() > 0) check_eq("kill_next_id", dut_ret[0], 4'd8);

    // Back-pressure holds the head result
    do_reset();
    do_issue(4'd2); do_commit(4'd2, 1'b0); do_ex(4'd2, 32'hDEAD_BEEF);
    do_idle(5, 1'b0);
    check_eq("hold_data", result_data_o, 32'hDEAD_BEEF);
    do_idle(3, 1'b1);
    check_eq("hold_single", dut_ret.size(), 1);

    // Protocol errors: unknown commit, double result, issue while full
    do_reset();
    do_commit(4'd9, 1'b0);
    do_issue(4'd4);
    do_ex(4'd4, 32'h44);
    do_ex(4'd4, 32'h99);
    do_commit(4'd4, 1'b0);
    do_idle(3, 1'b1);
    check_eq("err_sticky", err_o, 1'b1);
    for (int k = 0; k < 5; k++) do_issue(4'(k + 10));
    do_idle(1, 1'b1);

    // Duplicate live ID flags an error but still allocates
    do_reset();
    do_issue(4'd5); do_issue(4'd5);
    do_idle(1, 1'b1);
    check_eq("dup_alloc", outstanding_o, 3'd2);

    // Reset with work in flight, then a clean transaction using ID 0
    do_reset();
    do_issue(4'd1); do_issue(4'd2); do_issue(4'd3);
    do_reset();
    do_issue(4'd0); do_commit(4'd0, 1'b0); do_ex(4'd0, 32'h1234);
    do_idle(3, 1'b1);
    check_eq("post_rst_count", dut_ret.size(), 1);
    if (dut_ret.size() > 0) check_eq("post_rst_id", dut_ret[0], 4'd0);

    // Randomised legal traffic
    do_reset();
    for (int n = 0; n < 800; n++) rand_cycle();
    do_idle(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/xif_commit_tracker.md
Name: xif_commit_tracker

Overview:
- Parametrised in-order tracker for CV-X-IF offloaded instructions inside the coprocessor, between the issue decoder, the execution units and the core's result interface.
- Allocates an entry per accepted issue, applies commit/kill from the core and absorbs out-of-order execution results.
- Returns exactly one x_result per committed, non-killed instruction, in issue order.
- Generalises the fixed X_ID_WIDTH/X_RFW_WIDTH interface to configurable depth, ID width and dual-writeback width; adds kill handling and protocol-error detection.

Parameters:
- X_ID_WIDTH, 4, offloaded instruction ID width.
- DEPTH, 4, maximum outstanding instructions; power of two, 2..16.
- X_RFW_WIDTH, 32, result data width; XLEN or 2*XLEN.
- XLEN, 32, integer register width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  accepted issue handshake valid
- issue_ready_o  out  1  free entry available
- issue_id_i  in  X_ID_WIDTH  ID of accepted instruction
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  X_ID_WIDTH  committed/killed ID
- commit_kill_i  in  1  1 = kill
- ex_valid_i  in  1  execution result valid
- ex_ready_o  out  1  always 1 after reset
- ex_id_i  in  X_ID_WIDTH  result ID
- ex_data_i  in  X_RFW_WIDTH  write data
- ex_rd_i  in  5  destination register
- ex_we_i  in  X_RFW_WIDTH/XLEN  write enables
- ex_exc_i  in  1  exception
- ex_exccode_i  in  6  exception code
- result_valid_o  out  1  core result valid
- result_ready_i  in  1  core accepts result
- result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o, result_exccode_o  out  widths as ex_*  head result fields
- outstanding_o  out  $clog2(DEPTH+1)  occupied entries
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_ni low): all entries FREE, head = tail = 0, outstanding_o = 0, err_o = 0, result_* = 0, issue_ready_o = 1, ex_ready_o = 1. Reset mid-operation discards all entries and results; no result is emitted.
- Entry fields: state {FREE, ISSUED, COMMITTED, KILLED}, id, has_res, stored result fields. Circular buffer with head/tail pointers, wrap at DEPTH.
- Issue: issue_valid_i & issue_ready_o writes tail entry (ISSUED, has_res = 0), tail++. issue_ready_o = (outstanding < DEPTH), combinational from registered count.
- issue_valid_i while full: ignored and err_o set.
- Commit: CAM over non-FREE entries plus the entry being written this cycle. A match moves ISSUED to COMMITTED (kill = 0) or to KILLED (kill = 1).
- Commit with no match, or targeting an entry not in ISSUED: err_o set, no state change.
- Exec result: CAM match on non-FREE entries; stores fields, has_res = 1.
- Exec result with no match, or a second result for the same ID: err_o set, data dropped.
- Commit and exec for the same ID in the same cycle both apply.
- Retire, head entry only:
  - COMMITTED & has_res: result_valid_o = 1, result_* from entry. Combinational from registered state, so earliest result_valid_o is 1 cycle after the ex handshake. Entry freed and head++ on result_ready_i. result_* stay stable while valid & !ready.
  - KILLED & has_res: freed silently in 1 cycle, result_valid_o = 0.
  - Otherwise: head stalls; younger completed entries wait.
- Simultaneous issue and retire: outstanding unchanged; issue allowed when full only if the count is < DEPTH at cycle start (no bypass).
- Exactly one retire per cycle maximum.
- outstanding_o = registered count.
- IDs must be unique among outstanding entries. An issue duplicating a live ID sets err_o and is still allocated.

Decomposition:
- Shared package xif_pkg gains DEPTH-independent typedefs: tracker entry state enum and x_exec_result_t (id, data, rd, we, exc, exccode).
- Existing x_result_t is reused for result_* packing.
- One sub-module is natural: xif_id_cam (parametrised DEPTH x X_ID_WIDTH match vector with valid mask, one-hot output plus hit flag), instantiated twice (commit, exec).

Test Plan:
- Issue IDs 1, 2, 3; commit 1, 2, 3; ex results in order 3, 1, 2 with data 0x33/0x11/0x22 -> core results IDs 1, 2, 3 in order with matching data; outstanding_o returns to 0.
- DEPTH = 4: issue 5 IDs back-to-back -> issue_ready_o = 0 after the 4th, 5th not accepted, err_o stays 0 if issue_valid_i is held off; retire one -> issue_ready_o = 1 next cycle.
- Issue 7, commit with kill = 1, ex result for 7 -> no result_valid_o; entry freed; the next instruction's result follows immediately.
- Hold result_ready_i = 0 for 5 cycles with head ready -> result_valid_o stays 1 and result_data_o stable; release -> single retire.
- Commit ID 9 never issued; ex result for ID 4 twice -> err_o = 1 and sticky; tracker state unchanged by the bad events.
- Assert rst_ni low with 3 entries outstanding -> outputs at reset values immediately; after release, a fresh issue/commit/result completes with ID 0 accepted.
